// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and dmemory port signals of the load/store unit
interface load_store_unit_if;
    logic        req_in;
    logic        we_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        busy_out;
    logic        done_out;
    logic        err_out;
    logic [31:0] rdata_out;
    logic        mem_wr_en_out;
    logic [31:0] mem_wr_addr_out;
    logic [31:0] mem_wr_data_out;
    logic [31:0] mem_rd_addr_out;
    logic [31:0] mem_rd_data_in;

    modport slave (
        input  req_in, we_in, funct3_in, addr_in, wdata_in, mem_rd_data_in,
        output busy_out, done_out, err_out, rdata_out,
        output mem_wr_en_out, mem_wr_addr_out, mem_wr_data_out, mem_rd_addr_out
    );

    modport master (
        output req_in, we_in, funct3_in, addr_in, wdata_in, mem_rd_data_in,
        input  busy_out, done_out, err_out, rdata_out,
        input  mem_wr_en_out, mem_wr_addr_out, mem_wr_data_out, mem_rd_addr_out
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I loads/stores onto a word-wide memory without byte strobes (sub-word stores use read-modify-write)
module load_store_unit (
    input logic             clkin,
    input logic             nrst_in,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE} state_t;
    state_t      state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] wr_data_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        store_hi;
    logic        ok;
    logic [4:0]  sh;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] ld_val;
    logic [31:0] mask;
    logic [31:0] merged;

    always_comb begin
        store_hi = bus.we_in & bus.funct3_in[2];
        ok = ~store_hi & ((bus.funct3_in[1:0] == 2'b00) |
                          (bus.funct3_in[1:0] == 2'b01 & ~bus.addr_in[0]) |
                          (bus.funct3_in == 3'b010 & bus.addr_in[1:0] == 2'b00));
        sh = {addr_q[1:0], 3'b000};
        lb = 8'(bus.mem_rd_data_in >> sh);
        lh = 16'(bus.mem_rd_data_in >> sh);
        ld_val = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & lb[7]}}, lb} :
                 f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & lh[15]}}, lh} : bus.mem_rd_data_in;
        mask = (f3_q[0] ? 32'h0000_ffff : 32'h0000_00ff) << sh;
        merged = (bus.mem_rd_data_in & ~mask) | ((wdata_q << sh) & mask);
    end

    always_ff @(posedge clkin or negedge nrst_in) begin
        if (!nrst_in) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            wr_data_q <= 32'h0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_in) begin
                    we_q    <= bus.we_in;
                    f3_q    <= bus.funct3_in;
                    addr_q  <= bus.addr_in;
                    wdata_q <= bus.wdata_in;
                    err_q   <= ~ok;
                    if (bus.we_in) wr_data_q <= bus.wdata_in;
                    state <= !ok ? DONE : !bus.we_in ? LOAD :
                             bus.funct3_in[1:0] == 2'b10 ? WRITE : RMW_RD;
                end
                LOAD: begin
                    rdata_q <= ld_val;
                    state   <= DONE;
                end
                RMW_RD: begin
                    wr_data_q <= merged;
                    state     <= WRITE;
                end
                WRITE:   state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_out        = state != IDLE;
    assign bus.done_out        = state == DONE;
    assign bus.mem_wr_en_out   = state == WRITE;
    assign bus.err_out         = err_q;
    assign bus.rdata_out       = rdata_q;
    assign bus.mem_wr_data_out = wr_data_q;
    assign bus.mem_wr_addr_out = {2'b00, addr_q[31:2]};
    assign bus.mem_rd_addr_out = {2'b00, addr_q[31:2]};
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: byte-level reference model of memory and load results checked against the unit each cycle
module tb_load_store_unit;
    logic clkin = 1'b0;
    logic nrst_in = 1'b0;
    load_store_unit_if io();

    load_store_unit dut (.clkin(clkin), .nrst_in(nrst_in), .bus(io));

    always #5 clkin = ~clkin;

    bit [31:0] mem [64];
    bit [7:0]  bm [256];
    int        checks = 0;
    int        errors = 0;
    int        wr_cnt = 0;
    logic [31:0] exp_rdata = 32'h0;
    logic [31:0] last_wr = 32'h0;
    logic        last_err = 1'b0;

    assign io.mem_rd_data_in = mem[io.mem_rd_addr_out[5:0]];

    always @(posedge clkin) if (io.mem_wr_en_out) begin
        mem[io.mem_wr_addr_out[5:0]] <= io.mem_wr_data_out;
        wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal_ref(input bit w, input bit [2:0] f, input int a);
        case (f)
            3'd0:    return 1'b1;
            3'd1:    return a % 2 == 0;
            3'd2:    return a % 4 == 0;
            3'd4:    return !w;
            3'd5:    return !w && a % 2 == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_ref(input bit [2:0] f, input int a);
        case (f)
            3'd0:    return {{24{bm[a][7]}}, bm[a]};
            3'd4:    return {24'h0, bm[a]};
            3'd1:    return {{16{bm[a+1][7]}}, bm[a+1], bm[a]};
            3'd5:    return {16'h0, bm[a+1], bm[a]};
            default: return {bm[a+3], bm[a+2], bm[a+1], bm[a]};
        endcase
    endfunction

    task automatic store_ref(input bit [2:0] f, input int a, input logic [31:0] d);
        int n;
        n = f == 3'd0 ? 1 : f == 3'd1 ? 2 : 4;
        for (int i = 0; i < n; i++) bm[a+i] = d[8*i +: 8];
    endtask

    // Called at a negedge with the unit idle; returns at the negedge of the following idle cycle.
    task automatic op(input bit w, input bit [2:0] f, input int a, input logic [31:0] d, input bit hold);
        bit lg;
        int lat;
        int wi;
        logic [31:0] new_rd;
        logic [31:0] wword;
        lg = legal_ref(w, f, a);
        lat = !lg ? 1 : (!w || f == 3'd2) ? 2 : 3;
        wi = a / 4;
        new_rd = (lg && !w) ? load_ref(f, a) : exp_rdata;
        if (lg && w) store_ref(f, a, d);
        wword = {bm[wi*4+3], bm[wi*4+2], bm[wi*4+1], bm[wi*4]};
        io.req_in = 1'b1;
        io.we_in = w;
        io.funct3_in = f;
        io.addr_in = a;
        io.wdata_in = d;
        @(posedge clkin);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clkin);
            if (k == 1 && !hold) io.req_in = 1'b0;
            chk("busy", io.busy_out, k <= lat);
            chk("done", io.done_out, k == lat);
            chk("wr_en", io.mem_wr_en_out, lg && w && k == lat - 1);
            chk("rd_addr", io.mem_rd_addr_out, wi);
            chk("rdata", io.rdata_out, k >= lat ? new_rd : exp_rdata);
            if (k == lat) begin
                chk("err", io.err_out, !lg);
                last_err = io.err_out;
            end
            if (io.mem_wr_en_out) begin
                chk("wr_addr", io.mem_wr_addr_out, wi);
                chk("wr_data", io.mem_wr_data_out, wword);
                last_wr = io.mem_wr_data_out;
            end
        end
        exp_rdata = new_rd;
    endtask

    initial begin
        int wc;
        logic [31:0] d;
        int a;
        io.req_in = 1'b0;
        io.we_in = 1'b0;
        io.funct3_in = 3'd0;
        io.addr_in = 32'h0;
        io.wdata_in = 32'h0;
        repeat (2) @(negedge clkin);
        chk("rst_busy", io.busy_out, 0);
        chk("rst_done", io.done_out, 0);
        chk("rst_err", io.err_out, 0);
        chk("rst_wr_en", io.mem_wr_en_out, 0);
        chk("rst_rdata", io.rdata_out, 0);
        chk("rst_wr_data", io.mem_wr_data_out, 0);
        chk("rst_wr_addr", io.mem_wr_addr_out, 0);
        chk("rst_rd_addr", io.mem_rd_addr_out, 0);
        nrst_in = 1'b1;
        @(negedge clkin);

        wc = wr_cnt;
        op(1, 3'd2, 'h10, 32'hDEADBEEF, 0);
        chk("sw_pulses", wr_cnt - wc, 1);
        chk("sw_lit", last_wr, 32'hDEADBEEF);
        op(0, 3'd2, 'h10, 0, 0);
        chk("lw_lit", io.rdata_out, 32'hDEADBEEF);
        op(0, 3'd0, 'h13, 0, 0);
        chk("lb13_lit", io.rdata_out, 32'hFFFFFFDE);
        op(0, 3'd4, 'h13, 0, 0);
        chk("lbu13_lit", io.rdata_out, 32'h000000DE);
        op(0, 3'd0, 'h10, 0, 0);
        chk("lb10_lit", io.rdata_out, 32'hFFFFFFEF);
        op(0, 3'd1, 'h12, 0, 0);
        chk("lh12_lit", io.rdata_out, 32'hFFFFDEAD);
        op(0, 3'd5, 'h10, 0, 0);
        chk("lhu10_lit", io.rdata_out, 32'h0000BEEF);

        wc = wr_cnt;
        op(0, 3'd2, 'h11, 0, 0);
        chk("err_lw_lit", last_err, 1);
        op(1, 3'd1, 'h13, 32'h5555, 0);
        chk("err_sh_lit", last_err, 1);
        op(0, 3'd3, 'h10, 0, 0);
        chk("err_f3l_lit", last_err, 1);
        op(1, 3'd4, 'h10, 32'h77, 0);
        chk("err_f3s_lit", last_err, 1);
        chk("err_no_write", wr_cnt - wc, 0);
        chk("err_rdata_lit", io.rdata_out, 32'h0000BEEF);

        wc = wr_cnt;
        op(1, 3'd0, 'h11, 32'h123456AA, 0);
        chk("sb_lit", last_wr, 32'hDEADAAEF);
        chk("sb_pulses", wr_cnt - wc, 1);
        op(1, 3'd2, 'h10, 32'hDEADBEEF, 0);
        wc = wr_cnt;
        op(1, 3'd1, 'h12, 32'h00001234, 0);
        chk("sh_lit", last_wr, 32'h1234BEEF);
        chk("sh_pulses", wr_cnt - wc, 1);
        op(1, 3'd2, 'h10, 32'hDEADBEEF, 0);

        // Reset while the read-modify-write read is in flight.
        wc = wr_cnt;
        io.req_in = 1'b1;
        io.we_in = 1'b1;
        io.funct3_in = 3'd0;
        io.addr_in = 'h11;
        io.wdata_in = 32'h000000CC;
        @(posedge clkin);
        #2 nrst_in = 1'b0;
        #1;
        io.req_in = 1'b0;
        chk("mid_rst_busy", io.busy_out, 0);
        chk("mid_rst_done", io.done_out, 0);
        chk("mid_rst_wr_en", io.mem_wr_en_out, 0);
        chk("mid_rst_rdata", io.rdata_out, 0);
        exp_rdata = 32'h0;
        repeat (2) @(negedge clkin);
        nrst_in = 1'b1;
        @(negedge clkin);
        chk("mid_rst_no_write", wr_cnt - wc, 0);
        op(0, 3'd2, 'h10, 0, 0);
        chk("mid_rst_mem_lit", io.rdata_out, 32'hDEADBEEF);

        for (int i = 0; i < 8; i++) begin
            a = 'h40 + 4 * (i / 2);
            if (i % 2 == 0) begin
                d = $urandom;
                op(1, 3'd2, a, d, 1);
            end else begin
                op(0, 3'd2, a, 0, 1);
                chk("b2b_lw", io.rdata_out, d);
            end
        end
        io.req_in = 1'b0;
        @(negedge clkin);
        chk("b2b_idle", io.busy_out, 0);

        for (int i = 0; i < 300; i++) begin
            a = $urandom_range(0, 255);
            if ($urandom_range(0, 1) == 1) a = a & ~3;
            op($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), a, $urandom, $urandom_range(0, 3) == 0);
            io.req_in = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
